// File: rtl/force_reg_drainer.sv
// rtl/force_reg_drainer.sv - round-robin drainer for upstream force registers
package force_reg_pkg;
  typedef struct packed {
    logic [31:0] f;
    logic [2:0]  cid;
    logic [7:0]  parid;
  } force_packet_t;
endpackage

module force_reg_drainer
  import force_reg_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REGS-1:0]          i_reg_valid,
  input  force_packet_t [NUM_REGS-1:0] i_regs,
  output logic [NUM_REGS-1:0]          o_release_select,
  output logic [NUM_REGS-1:0]          o_lock,
  output force_packet_t                o_pkt,
  output logic                         o_valid,
  input  logic                         i_ready
);

  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   cur_idx;
  logic [IDX_W-1:0]   sel;
  logic [IDX_W-1:0]   ptr_nxt;
  logic               sel_found;
  logic [NUM_REGS-1:0] cur_onehot;
  int                 scan_idx;

  // First valid register at or after rr_ptr, wrapping modulo NUM_REGS.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    scan_idx  = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      scan_idx = (int'(rr_ptr) + i) % NUM_REGS;
      if (!sel_found && i_reg_valid[IDX_W'(scan_idx)]) begin
        sel_found = 1'b1;
        sel       = IDX_W'(scan_idx);
      end
    end
  end

  assign ptr_nxt    = (cur_idx == IDX_W'(NUM_REGS - 1)) ? '0 : cur_idx + IDX_W'(1);
  assign cur_onehot = NUM_REGS'(1) << cur_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    o_valid          = 1'b0;
    o_lock           = '0;
    o_release_select = '0;
    case (state)
      IDLE: begin
        if (sel_found) state_nxt = SEND;
      end
      SEND: begin
        o_valid = 1'b1;
        o_lock  = cur_onehot;
        if (i_ready) state_nxt = RELEASE;
      end
      RELEASE: begin
        o_lock           = cur_onehot;
        o_release_select = cur_onehot;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // o_pkt is captured once at the scan so upstream changes cannot disturb it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr  <= '0;
      cur_idx <= '0;
      o_pkt   <= '0;
    end else begin
      if (state == IDLE && sel_found) begin
        o_pkt   <= i_regs[sel];
        cur_idx <= sel;
      end
      if (state == SEND && i_ready) begin
        rr_ptr <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_force_reg_drainer.sv
// tb/tb_force_reg_drainer.sv - scoreboard bench for force_reg_drainer
module tb_force_reg_drainer;
  import force_reg_pkg::*;

  localparam int N = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  i_ready = 1'b0;
  logic [N-1:0]          rv = '0;
  force_packet_t [N-1:0] regs;
  logic [N-1:0]          o_release_select;
  logic [N-1:0]          o_lock;
  force_packet_t         o_pkt;
  logic                  o_valid;

  typedef struct {
    int            idx;
    force_packet_t pkt;
  } exp_t;

  exp_t          sb[$];
  int            hs_cyc[$];
  int            errors = 0;
  int            checks = 0;
  logic [N-1:0]  load_mask = '0;
  int            load_seq = 0;
  int            seen_seq = 0;
  int            cyc = 0;
  int            run_len = 0;
  int            last_run = 0;
  logic          pending = 1'b0;
  int            pend_idx = 0;
  force_packet_t held;

  force_reg_drainer #(.NUM_REGS(N)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_reg_valid      (rv),
    .i_regs           (regs),
    .o_release_select (o_release_select),
    .o_lock           (o_lock),
    .o_pkt            (o_pkt),
    .o_valid          (o_valid),
    .i_ready          (i_ready)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic force_packet_t mk(logic [31:0] f, logic [2:0] c, logic [7:0] p);
    force_packet_t r;
    r.f     = f;
    r.cid   = c;
    r.parid = p;
    return r;
  endfunction

  // Upstream register model and output monitor; sole owner of rv.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (load_seq != seen_seq) begin
      rv       = rv | load_mask;
      seen_seq = load_seq;
    end
    if (!rst) begin
      run_len = 0;
      pending = 1'b0;
    end else begin
      if (pending) begin
        check("release_pulse", 64'(o_release_select), 64'(1) << pend_idx);
        check("release_lock", 64'(o_lock), 64'(1) << pend_idx);
        rv[pend_idx] = 1'b0;
        pending      = 1'b0;
      end else begin
        check("no_release", 64'(o_release_select), 64'(0));
        if (!o_valid) check("idle_lock", 64'(o_lock), 64'(0));
      end
      if (o_valid) begin
        if (run_len == 0) held = o_pkt;
        else check("pkt_stable", 64'(o_pkt), 64'(held));
        run_len++;
        if (sb.size() == 0) begin
          check("unexpected_pkt", 64'(o_pkt), 64'(0));
        end else begin
          check("send_lock", 64'(o_lock), 64'(1) << sb[0].idx);
          if (i_ready) begin
            e = sb.pop_front();
            check("pkt", 64'(o_pkt), 64'(e.pkt));
            pending  = 1'b1;
            pend_idx = e.idx;
            hs_cyc.push_back(cyc);
          end
        end
      end else begin
        if (run_len > 0) last_run = run_len;
        run_len = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(logic [N-1:0] m);
    load_mask = m;
    load_seq++;
  endtask

  task automatic push(int idx);
    exp_t e;
    e.idx = idx;
    e.pkt = regs[idx];
    sb.push_back(e);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!o_valid && n < 50) begin
      tick();
      n++;
    end
    check("valid_timeout", 64'(o_valid), 64'(1));
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || pending) && n < 200) begin
      tick();
      n++;
    end
    check("drain", 64'(sb.size() == 0 && !pending), 64'(1));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    regs = '0;
    repeat (2) tick();
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_lock", 64'(o_lock), 64'(0));
    check("rst_release", 64'(o_release_select), 64'(0));
    check("rst_pkt", 64'(o_pkt), 64'(0));
    rst = 1'b1;
    i_ready = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      check("empty_valid", 64'(o_valid), 64'(0));
      check("empty_lock", 64'(o_lock), 64'(0));
      check("empty_release", 64'(o_release_select), 64'(0));
    end

    for (int k = 0; k < N; k++) begin
      regs[k] = mk(32'h4000_0000 + 32'(k), 3'(k), 8'(16 + k));
      push(k);
    end
    load(4'b1111);
    drain();
    n = hs_cyc.size();
    for (int i = 1; i <= 3; i++) check("rr_period", 64'(hs_cyc[n-i] - hs_cyc[n-i-1]), 64'(3));

    regs[0] = mk(32'h3F80_0000, 3'h1, 8'h20);
    regs[3] = mk(32'hC000_0000, 3'h3, 8'h33);
    push(0);
    load(4'b1001);
    wait_valid();
    check("iso_lock", 64'(o_lock), 64'(4'b0001));
    regs[3] = mk(32'h4110_0000, 3'h6, 8'h3C);
    regs[1] = mk(32'h4220_0000, 3'h2, 8'h21);
    push(1);
    push(3);
    load(4'b0010);
    drain();

    regs[0] = mk(32'h3E80_0000, 3'h7, 8'h40);
    regs[1] = mk(32'h3F00_0000, 3'h4, 8'h41);
    push(0);
    push(1);
    load(4'b0011);
    drain();

    regs[2] = mk(32'h3FC0_0000, 3'h5, 8'h07);
    push(2);
    load(4'b0100);
    tick();
    check("lat_valid", 64'(o_valid), 64'(1));
    check("lat_pkt", 64'(o_pkt), 64'(mk(32'h3FC0_0000, 3'h5, 8'h07)));
    check("lat_lock", 64'(o_lock), 64'(4'b0100));
    drain();
    check("single_idle", 64'(o_valid), 64'(0));

    i_ready = 1'b0;
    regs[1] = mk(32'h4049_0FDB, 3'h2, 8'h55);
    push(1);
    load(4'b0010);
    wait_valid();
    repeat (5) tick();
    i_ready = 1'b1;
    drain();
    check("bp_run", 64'(last_run), 64'(6));

    i_ready = 1'b0;
    regs[2] = mk(32'hBF80_0000, 3'h5, 8'h77);
    push(2);
    load(4'b0100);
    wait_valid();
    tick();
    rst = 1'b0;
    #1;
    check("arst_valid", 64'(o_valid), 64'(0));
    check("arst_lock", 64'(o_lock), 64'(0));
    check("arst_release", 64'(o_release_select), 64'(0));
    check("arst_pkt", 64'(o_pkt), 64'(0));
    tick();
    tick();
    rst = 1'b1;
    i_ready = 1'b1;
    tick();
    check("reoffer_valid", 64'(o_valid), 64'(1));
    check("reoffer_pkt", 64'(o_pkt), 64'(mk(32'hBF80_0000, 3'h5, 8'h77)));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/force_reg_drainer.md
FORCE_REG_DRAINER -- requirements
Module: force_reg_drainer

Interface
REQ-001 Parameter NUM_REGS, default 4, sets the number of upstream force registers drained; legal range 2..16.
REQ-002 Parameter IDX_W, default $clog2(NUM_REGS), sets the index width.
REQ-003 Reset is asynchronous and active-low; one clock.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 i_reg_valid  input  NUM_REGS  per-register occupancy flag; bit k is 1 while register k holds an unsent packet.
REQ-007 i_regs  input  NUM_REGS x force_packet_t  current contents of each force register (f, cid, parid).
REQ-008 o_release_select  output  NUM_REGS  one-hot release strobe to the force registers; at most one bit set.
REQ-009 o_lock  output  NUM_REGS  one-hot; bit k is 1 while register k is being sent.
REQ-010 o_pkt  output  force_packet_t  packet being offered downstream.
REQ-011 o_valid  output  1  o_pkt is valid.
REQ-012 i_ready  input  1  downstream accepts o_pkt this cycle.

Function
REQ-013 The FSM SHALL have states IDLE, SEND and RELEASE.
REQ-014 IDLE: if any i_reg_valid bit is set, the FSM SHALL select the first set bit at or after rr_ptr, wrapping modulo NUM_REGS.
- Latch i_regs[sel] into o_pkt.
- Latch sel into cur_idx.
- Go to SEND.
REQ-015 IDLE with i_reg_valid all zero SHALL keep the FSM in IDLE with o_valid=0 and o_pkt unchanged.
REQ-016 o_valid SHALL be 1 exactly while in SEND; o_pkt SHALL be stable while o_valid=1.
REQ-017 SEND with i_ready=1 completes the handshake.
- Go to RELEASE.
- rr_ptr <= (cur_idx+1) mod NUM_REGS.
REQ-018 SEND with i_ready=0 SHALL hold state, o_pkt and o_valid.
REQ-019 RELEASE SHALL drive o_release_select = one-hot(cur_idx) for exactly one cycle, then go to IDLE.
REQ-020 o_release_select SHALL be 0 in IDLE and SEND.
REQ-021 o_lock SHALL be one-hot(cur_idx) in SEND and RELEASE, and 0 in IDLE.
- Upstream SHALL NOT assert i_select to a locked register.
- Upstream SHALL NOT assert i_select to the register being released (release/select exclusivity).
REQ-022 i_reg_valid SHALL be a combinational function of the register contents; the released register therefore reads invalid in the IDLE cycle after RELEASE.
REQ-023 Latency, IDLE scan to o_valid=1, SHALL be 1 cycle.
REQ-024 Minimum per-packet period SHALL be 3 cycles (IDLE, SEND, RELEASE) with i_ready held high.
REQ-025 Round-robin fairness: a continuously valid register SHALL be served within NUM_REGS packets.
REQ-026 Changes to i_reg_valid or i_regs of non-locked registers during SEND/RELEASE SHALL NOT affect o_pkt.
REQ-027 rr_ptr wrap: with cur_idx=NUM_REGS-1, the next rr_ptr SHALL be 0.

Reset
REQ-028 While rst=0 the block SHALL immediately force:
- state=IDLE
- rr_ptr=0
- cur_idx=0
- o_valid=0
- o_pkt=0
- o_release_select=0
- o_lock=0
REQ-029 Reset asserted mid-SEND or mid-RELEASE SHALL abort without issuing a release; the register stays valid and is resent after reset.
REQ-030 The first IDLE scan SHALL occur on the first rising edge after rst deasserts.

Verification
REQ-031 Single packet: reg2 valid (f=1.5, cid=3'h5, parid=7), i_ready=1.
- o_valid=1 one cycle later with that packet.
- o_release_select=4'b0100 for exactly one cycle next.
- Block returns to IDLE.
REQ-032 Round-robin: all 4 regs valid, i_ready=1.
- Service order 0,1,2,3, one packet every 3 cycles.
- Re-validating reg0 after reg3 is served gives reg0 next (wrap).
REQ-033 Backpressure: reg1 valid, i_ready=0 for 5 cycles, then 1.
- o_valid held for 6 cycles with o_pkt constant and o_lock=4'b0010.
- Release occurs only after the handshake.
REQ-034 Isolation: during SEND of reg0, reg3 changes contents and reg1 becomes valid.
- o_pkt unchanged.
- Next service is reg1, then reg3.
REQ-035 Reset mid-SEND: rst=0 while o_valid=1 for reg2.
- All outputs go 0 asynchronously with no release pulse.
- After reset, reg2 is re-offered with identical contents.
REQ-036 Empty: i_reg_valid=0 for 10 cycles -> o_valid, o_release_select and o_lock stay 0.
